// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: stall/reset encodings,
// the all-zero word, performance-counter width, NOP instruction fields and
// the per-cycle action encoding.
package pipe_pkg;

    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam logic RstEnable = 1'b1;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam int CNT_W = 16;

    // Field encodings of the canonical NOP (addi x0, x0, 0).
    localparam logic [6:0]  NOP_OPCODE = 7'h13;
    localparam logic [4:0]  NOP_RD     = 5'd0;
    localparam logic [2:0]  NOP_FUNCT3 = 3'b000;
    localparam logic [4:0]  NOP_RS1    = 5'd0;
    localparam logic [11:0] NOP_IMM    = 12'h000;

    // Assembles a 32-bit NOP word; callers pass it as NOP_VAL when a real
    // instruction-shaped bubble is wanted instead of all zeros.
    function automatic logic [31:0] nop_word();
        return {NOP_IMM, NOP_RS1, NOP_FUNCT3, NOP_RD, NOP_OPCODE};
    endfunction

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } stage_act_e;

endpackage

// File: rtl/sat_cnt.sv
// Width-parametrised saturating up-counter. clr wins over inc; the count
// sticks at all-ones instead of wrapping.
module sat_cnt
    import pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // Clear on reset or clr, otherwise count up until all-ones.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/bubble/flush handling.
// Action priority per cycle: rst, flush, bubble (own stall set, next stage
// free), hold (own and next stage stalled), load.
// Optional bubble/flush performance counters are built only when the macro
// PIPE_PERF_EN is defined; otherwise the counter ports read constant 0.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int             DW      = 32,
    parameter int             STALL_W = 6,
    parameter int             STAGE   = 2,
    parameter logic [DW-1:0]  NOP_VAL = DW'(ZeroWord)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [DW-1:0]      in_data,
    input  logic               in_valid,
    output logic [DW-1:0]      out_data,
    output logic               out_valid,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    if (STAGE >= STALL_W || STAGE < 0 || DW < 1) begin : g_bad_param
        $error("pipe_stage_reg: illegal parameters DW=%0d STALL_W=%0d STAGE=%0d",
               DW, STALL_W, STAGE);
    end

    logic               w_s_cur;
    logic               w_s_nxt;
    stage_act_e         w_act;
    logic [STALL_W-1:0] w_unused_stall;
    logic [DW-1:0]      r_data;
    logic               r_valid;

    assign w_s_cur        = stall[STAGE];
    assign w_unused_stall = stall;

    // The last stage has no downstream stall bit; treat it as never stalled.
    if (STAGE < STALL_W - 1) begin : g_nxt
        assign w_s_nxt = stall[STAGE+1];
    end else begin : g_last
        assign w_s_nxt = NoStop;
    end

    // Decode this cycle's action; s_cur=0 always loads, even if s_nxt=1.
    always_comb begin
        w_act = ACT_LOAD;
        if (flush) begin
            w_act = ACT_FLUSH;
        end else if (w_s_cur == Stop && w_s_nxt == NoStop) begin
            w_act = ACT_BUBBLE;
        end else if (w_s_cur == Stop) begin
            w_act = ACT_HOLD;
        end
    end

    // Payload register: reset/flush/bubble insert NOP, hold keeps, load captures.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_data  <= NOP_VAL;
            r_valid <= 1'b0;
        end else begin
            case (w_act)
                ACT_LOAD: begin
                    r_valid <= in_valid;
                    r_data  <= in_valid ? in_data : NOP_VAL;
                end
                ACT_HOLD: begin
                    r_valid <= r_valid;
                    r_data  <= r_data;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_data  <= NOP_VAL;
                end
            endcase
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;

`ifndef SYNTHESIS
    // A stage that is free while its successor is stalled means the stall
    // controller produced a non-monotonic vector.
    always_ff @(posedge clk) begin
        if (rst != RstEnable) begin
            assert (!(w_s_cur == NoStop && w_s_nxt == Stop))
            else $error("pipe_stage_reg: illegal stall vector %b at stage %0d", stall, STAGE);
        end
    end
`endif

`ifdef PIPE_PERF_EN
    sat_cnt #(.W(CNT_W)) u_bubble (
        .clk (clk),
        .rst (rst),
        .inc (w_act == ACT_BUBBLE),
        .clr (cnt_clr),
        .cnt (bubble_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_flush (
        .clk (clk),
        .rst (rst),
        .inc (w_act == ACT_FLUSH),
        .clr (cnt_clr),
        .cnt (flush_cnt)
    );
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign bubble_cnt       = '0;
    assign flush_cnt        = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a driver applies directed vectors and
// queues hand-computed expectations; a monitor pops one per clock and compares.
// Instance a: STAGE=2 with a NOP-instruction bubble value; instance b: STAGE=5.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOPA = 32'h0000_0013;
    localparam logic [31:0] NOPB = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b1, a_flush = 1'b0, a_valid = 1'b0, a_clr = 1'b0;
    logic [5:0]  a_stall = 6'b0;
    logic [31:0] a_data = 32'h0, a_odata;
    logic        a_ovalid;
    logic [15:0] a_bcnt, a_fcnt;

    logic        b_rst = 1'b1, b_flush = 1'b0, b_valid = 1'b0, b_clr = 1'b0;
    logic [5:0]  b_stall = 6'b0;
    logic [31:0] b_data = 32'h0, b_odata;
    logic        b_ovalid;
    logic [15:0] b_bcnt, b_fcnt;

    pipe_stage_reg #(.DW(32), .STALL_W(6), .STAGE(2), .NOP_VAL(NOPA)) dut_a (
        .clk(clk), .rst(a_rst), .stall(a_stall), .flush(a_flush),
        .in_data(a_data), .in_valid(a_valid), .out_data(a_odata),
        .out_valid(a_ovalid), .cnt_clr(a_clr), .bubble_cnt(a_bcnt),
        .flush_cnt(a_fcnt)
    );

    pipe_stage_reg #(.DW(32), .STALL_W(6), .STAGE(5)) dut_b (
        .clk(clk), .rst(b_rst), .stall(b_stall), .flush(b_flush),
        .in_data(b_data), .in_valid(b_valid), .out_data(b_odata),
        .out_valid(b_ovalid), .cnt_clr(b_clr), .bubble_cnt(b_bcnt),
        .flush_cnt(b_fcnt)
    );

    typedef struct {
        bit          sel;
        logic [31:0] d;
        logic        v;
        logic [15:0] b;
        logic [15:0] f;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   vec_id = 0;

    // Counter expectations collapse to 0 when the counters are not built.
    function automatic logic [15:0] pc(logic [15:0] x);
`ifdef PIPE_PERF_EN
        return x;
`else
        return 16'h0 & x;
`endif
    endfunction

    task automatic push_exp(bit sel, logic [31:0] d, logic v, logic [15:0] b, logic [15:0] f);
        exp_t e;
        e.sel = sel; e.d = d; e.v = v; e.b = pc(b); e.f = pc(f); e.id = vec_id;
        vec_id++;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic step_a(logic r, logic [5:0] s, logic fl, logic cl, logic v, logic [31:0] d,
                          logic [31:0] ed, logic ev, logic [15:0] eb, logic [15:0] ef);
        a_rst = r; a_stall = s; a_flush = fl; a_clr = cl; a_valid = v; a_data = d;
        push_exp(1'b0, ed, ev, eb, ef);
    endtask

    task automatic step_b(logic r, logic [5:0] s, logic fl, logic cl, logic v, logic [31:0] d,
                          logic [31:0] ed, logic ev, logic [15:0] eb, logic [15:0] ef);
        b_rst = r; b_stall = s; b_flush = fl; b_clr = cl; b_valid = v; b_data = d;
        push_exp(1'b1, ed, ev, eb, ef);
    endtask

    task automatic chk(string nm, int id, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: one sample per clock, just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (e.sel == 1'b0) begin
                    chk("a.out_data",   e.id, a_odata,          e.d);
                    chk("a.out_valid",  e.id, {31'b0, a_ovalid}, {31'b0, e.v});
                    chk("a.bubble_cnt", e.id, {16'b0, a_bcnt},  {16'b0, e.b});
                    chk("a.flush_cnt",  e.id, {16'b0, a_fcnt},  {16'b0, e.f});
                end else begin
                    chk("b.out_data",   e.id, b_odata,          e.d);
                    chk("b.out_valid",  e.id, {31'b0, b_ovalid}, {31'b0, e.v});
                    chk("b.bubble_cnt", e.id, {16'b0, b_bcnt},  {16'b0, e.b});
                    chk("b.flush_cnt",  e.id, {16'b0, b_fcnt},  {16'b0, e.f});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        //     rst  stall      fl  cl  v   data            exp_data      v   bcnt     fcnt
        step_a(1, 6'b000000, 0, 0, 1, 32'h1234_5678, NOPA,          0, 16'd0,  16'd0);
        step_a(1, 6'b000111, 1, 0, 1, 32'h1234_5678, NOPA,          0, 16'd0,  16'd0);
        step_a(0, 6'b000000, 0, 0, 1, 32'h1234_5678, 32'h1234_5678, 1, 16'd0,  16'd0);
        step_a(0, 6'b000000, 0, 0, 0, 32'hDEAD_BEEF, NOPA,          0, 16'd0,  16'd0);
        step_a(0, 6'b000000, 0, 0, 1, 32'h0000_00FF, 32'h0000_00FF, 1, 16'd0,  16'd0);
        step_a(0, 6'b000111, 0, 0, 1, 32'h1111_1111, NOPA,          0, 16'd1,  16'd0);
        step_a(0, 6'b000111, 0, 0, 1, 32'h2222_2222, NOPA,          0, 16'd2,  16'd0);
        step_a(0, 6'b000111, 0, 0, 1, 32'h3333_3333, NOPA,          0, 16'd3,  16'd0);
        step_a(0, 6'b000000, 0, 0, 1, 32'hAAAA_0001, 32'hAAAA_0001, 1, 16'd3,  16'd0);
        step_a(0, 6'b001111, 0, 0, 1, 32'h5555_0001, 32'hAAAA_0001, 1, 16'd3,  16'd0);
        step_a(0, 6'b001111, 0, 0, 0, 32'h5555_0002, 32'hAAAA_0001, 1, 16'd3,  16'd0);
        step_a(0, 6'b001111, 0, 0, 1, 32'h5555_0003, 32'hAAAA_0001, 1, 16'd3,  16'd0);
        step_a(0, 6'b001111, 0, 0, 1, 32'h5555_0004, 32'hAAAA_0001, 1, 16'd3,  16'd0);
        step_a(0, 6'b000111, 1, 0, 1, 32'h6666_0000, NOPA,          0, 16'd3,  16'd1);
        step_a(0, 6'b000111, 0, 1, 1, 32'h6666_0001, NOPA,          0, 16'd0,  16'd0);
        step_a(0, 6'b000000, 0, 0, 1, 32'hBBBB_0002, 32'hBBBB_0002, 1, 16'd0,  16'd0);
        step_a(0, 6'b001111, 0, 0, 1, 32'h7777_0000, 32'hBBBB_0002, 1, 16'd0,  16'd0);
        step_a(0, 6'b001111, 1, 0, 1, 32'h7777_0001, NOPA,          0, 16'd0,  16'd1);
        step_a(0, 6'b000000, 1, 1, 1, 32'h7777_0002, NOPA,          0, 16'd0,  16'd0);
        step_a(0, 6'b000000, 1, 0, 1, 32'hCCCC_0000, NOPA,          0, 16'd0,  16'd1);
        step_a(0, 6'b000000, 0, 1, 1, 32'hCCCC_0003, 32'hCCCC_0003, 1, 16'd0,  16'd0);
        step_a(0, 6'b001111, 0, 0, 1, 32'h9999_0000, 32'hCCCC_0003, 1, 16'd0,  16'd0);
        step_a(1, 6'b001111, 0, 0, 1, 32'h9999_0001, NOPA,          0, 16'd0,  16'd0);
        step_a(0, 6'b001111, 0, 0, 1, 32'h9999_0002, NOPA,          0, 16'd0,  16'd0);
        step_a(0, 6'b111111, 0, 0, 1, 32'h9999_0003, NOPA,          0, 16'd0,  16'd0);
        step_a(0, 6'b000100, 0, 0, 1, 32'h9999_0004, NOPA,          0, 16'd1,  16'd0);
        step_a(0, 6'b000000, 0, 0, 1, 32'hDDDD_0004, 32'hDDDD_0004, 1, 16'd1,  16'd0);
`ifdef PIPE_PERF_EN
        dut_a.u_bubble.r_cnt = 16'hFFFE;
`endif
        step_a(0, 6'b000111, 0, 0, 1, 32'hEEEE_0000, NOPA,          0, 16'hFFFF, 16'd0);
        step_a(0, 6'b000111, 0, 0, 1, 32'hEEEE_0001, NOPA,          0, 16'hFFFF, 16'd0);
`ifdef PIPE_PERF_EN
        dut_a.u_flush.r_cnt = 16'hFFFF;
`endif
        step_a(0, 6'b000000, 1, 0, 1, 32'hEEEE_0002, NOPA,          0, 16'hFFFF, 16'hFFFF);
        step_a(0, 6'b000111, 0, 1, 1, 32'hEEEE_0003, NOPA,          0, 16'd0,  16'd0);
        step_a(1, 6'b000000, 0, 0, 0, 32'h0000_0000, NOPA,          0, 16'd0,  16'd0);

        step_b(1, 6'b100000, 0, 0, 1, 32'h7777_0007, NOPB,          0, 16'd0,  16'd0);
        step_b(0, 6'b000000, 0, 0, 1, 32'h7777_0007, 32'h7777_0007, 1, 16'd0,  16'd0);
        step_b(0, 6'b100000, 0, 0, 1, 32'h7777_0008, NOPB,          0, 16'd1,  16'd0);
        step_b(0, 6'b011111, 0, 0, 1, 32'h8888_0008, 32'h8888_0008, 1, 16'd1,  16'd0);
        step_b(0, 6'b100000, 0, 0, 1, 32'h8888_0009, NOPB,          0, 16'd2,  16'd0);
        step_b(0, 6'b100000, 1, 0, 1, 32'h8888_000A, NOPB,          0, 16'd2,  16'd1);
        step_b(1, 6'b100000, 0, 0, 1, 32'h8888_000B, NOPB,          0, 16'd0,  16'd0);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        if (n_vec != vec_id) begin
            n_err++;
            $display("FAIL vector_count: checked %0d expected %0d", n_vec, vec_id);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
